// File: rtl/canvas_writer.sv
// Canvas writer: arbitrates camera pixels, pen stamps and full-frame erase onto one frame BRAM port.
// Every BRAM/status output is registered; a write decided in one cycle is on the port the next.
module canvas_writer #(
  parameter int H_PIXELS   = 320,
  parameter int V_PIXELS   = 240,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cam_valid_in,
  input  logic [8:0]  cam_x_in,
  input  logic [7:0]  cam_y_in,
  input  logic [7:0]  cam_gray_in,
  output logic        cam_ready_out,
  input  logic        pen_valid_in,
  input  logic [8:0]  pen_x_in,
  input  logic [7:0]  pen_y_in,
  input  logic [1:0]  pen_color_in,
  input  logic [2:0]  pen_radius_in,
  output logic        pen_ready_out,
  input  logic        clear_in,
  output logic [16:0] bram_addr_out,
  output logic        bram_we_out,
  output logic [7:0]  bram_din_out,
  input  logic [7:0]  bram_dout_in,
  output logic        busy_out,
  output logic        clear_done_out
);

  localparam int NPIX = H_PIXELS * V_PIXELS;
  localparam int WW   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, CAM_RD, CAM_WAIT, CAM_WR, STAMP, CLEAR} state_t;

  state_t        state_q, state_d;
  logic          clr_pend_q, clr_pend_d;
  logic          rdy_q, rdy_d, busy_q, busy_d, done_q, done_d, we_q, we_d;
  logic [16:0]   addr_q, addr_d;
  logic [7:0]    din_q, din_d;
  logic [16:0]   cam_addr_q;
  logic [7:0]    gray_q;
  logic [8:0]    cx_q;
  logic [7:0]    cy_q;
  logic [1:0]    color_q;
  logic [2:0]    r_q;
  logic [3:0]    dx_q, dy_q;
  logic [WW-1:0] wait_q;
  logic [16:0]   clr_cnt_q;

  function automatic logic [16:0] pix_addr(input logic [10:0] x, input logic [10:0] y);
    return 17'({6'b0, y} * 17'(H_PIXELS)) + {6'b0, x};
  endfunction

  logic        clear_req, pen_acc, cam_acc, cam_in_frame;
  logic [3:0]  r_s, neg_r;
  logic [10:0] sx, sy;
  logic        stamp_in_frame, dx_last, dy_last, clr_last, rd_done;

  // A held pen request masks the camera so only one handshake lands per cycle.
  assign pen_ready_out = rdy_q & ~clear_in;
  assign cam_ready_out = rdy_q & ~clear_in & ~pen_valid_in;
  assign pen_acc       = pen_valid_in & pen_ready_out;
  assign cam_acc       = cam_valid_in & cam_ready_out;
  assign clear_req     = clear_in | clr_pend_q;
  assign cam_in_frame  = ({2'b00, cam_x_in} < 11'(H_PIXELS)) && ({3'b000, cam_y_in} < 11'(V_PIXELS));

  // 11-bit two's-complement offsets: negative results are clipped, never wrapped.
  assign r_s            = {1'b0, r_q};
  assign neg_r          = 4'd0 - r_s;
  assign sx             = {2'b00, cx_q} + {{7{dx_q[3]}}, dx_q};
  assign sy             = {3'b000, cy_q} + {{7{dy_q[3]}}, dy_q};
  assign stamp_in_frame = !sx[10] && (sx < 11'(H_PIXELS)) && !sy[10] && (sy < 11'(V_PIXELS));
  assign dx_last        = (dx_q == r_s);
  assign dy_last        = (dy_q == r_s);
  assign clr_last       = (clr_cnt_q == 17'(NPIX - 1));
  assign rd_done        = (wait_q == WW'(RD_LATENCY - 1));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d    = CLEAR;
          clr_pend_d = 1'b0;
        end else if (pen_acc) begin
          state_d = STAMP;
        end else if (cam_acc && cam_in_frame) begin
          state_d = CAM_RD;
        end
      end
      CAM_RD:   state_d = CAM_WAIT;
      CAM_WAIT: if (rd_done) state_d = CAM_WR;
      CAM_WR:   state_d = IDLE;
      STAMP:    if (dx_last && dy_last) state_d = IDLE;
      CLEAR:    if (clr_last) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (state_q != IDLE && clear_in) clr_pend_d = 1'b1;
  end

  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    din_d  = din_q;
    done_d = 1'b0;
    case (state_q)
      CAM_RD: addr_d = cam_addr_q;
      CAM_WR: begin
        addr_d = cam_addr_q;
        din_d  = gray_q;
        we_d   = ((bram_dout_in & 8'hC0) != 8'hC0);
      end
      STAMP: begin
        addr_d = pix_addr(sx, sy);
        din_d  = {2'b11, 4'b0000, color_q};
        we_d   = stamp_in_frame;
      end
      CLEAR: begin
        addr_d = clr_cnt_q;
        din_d  = 8'h00;
        we_d   = 1'b1;
        done_d = clr_last;
      end
      default: ;
    endcase
    rdy_d  = (state_d == IDLE) && !clr_pend_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cam_addr_q <= '0;
      gray_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      color_q    <= '0;
      r_q        <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      wait_q     <= '0;
      clr_cnt_q  <= '0;
    end else begin
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
      done_q <= done_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      din_q  <= din_d;
      case (state_q)
        IDLE: begin
          clr_cnt_q <= '0;
          if (pen_acc) begin
            cx_q    <= pen_x_in;
            cy_q    <= pen_y_in;
            color_q <= pen_color_in;
            r_q     <= pen_radius_in;
            dx_q    <= 4'd0 - {1'b0, pen_radius_in};
            dy_q    <= 4'd0 - {1'b0, pen_radius_in};
          end else if (cam_acc) begin
            cam_addr_q <= pix_addr({2'b00, cam_x_in}, {3'b000, cam_y_in});
            gray_q     <= cam_gray_in >> 2;
          end
        end
        CAM_RD:   wait_q <= '0;
        CAM_WAIT: wait_q <= wait_q + 1'b1;
        STAMP: begin
          if (dx_last) begin
            dx_q <= neg_r;
            dy_q <= dy_q + 4'd1;
          end else begin
            dx_q <= dx_q + 4'd1;
          end
        end
        CLEAR:   clr_cnt_q <= clr_cnt_q + 17'd1;
        default: ;
      endcase
    end
  end

  assign bram_addr_out  = addr_q;
  assign bram_we_out    = we_q;
  assign bram_din_out   = din_q;
  assign busy_out       = busy_q;
  assign clear_done_out = done_q;

endmodule
